// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a latched pattern out LSB-first over a
// valid/ready link, with optional continuous repeat and synchronous abort.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start with non-zero len; dout/dout_vld low
// ST_SEND | presenting shift register bit 0 with dout_vld high
// ST_DONE | single cycle with done high after the last bit transfers
module seq_gen #(
    parameter int W  = 16,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  pat,
    input  logic [LW-1:0] len,
    input  logic          rpt,
    input  logic          abort,
    input  logic          dout_rdy,
    output logic          dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  pcopy;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_q;
    logic          rpt_q;
    logic          rpt_pulse;

    logic [LW-1:0] len_eff;
    logic          accept;
    logic          xfer;
    logic          last;

    assign len_eff = (len > LW'(W)) ? LW'(W) : len;
    assign accept  = (state == ST_IDLE) && start && (len != '0) && !abort;
    assign xfer    = (state == ST_SEND) && dout_rdy;
    assign last    = xfer && (cnt == LW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEND;
            ST_SEND: if (last && !rpt_q) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    // Datapath: shift register, pattern copy, down-counter and repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            pcopy     <= '0;
            cnt       <= '0;
            len_q     <= '0;
            rpt_q     <= 1'b0;
            rpt_pulse <= 1'b0;
        end else begin
            rpt_pulse <= 1'b0;
            if (abort) begin
                rpt_pulse <= 1'b0;
            end else if (accept) begin
                shreg <= pat;
                pcopy <= pat;
                cnt   <= len_eff;
                len_q <= len_eff;
                rpt_q <= rpt;
            end else if (xfer) begin
                if (last && rpt_q) begin
                    shreg     <= pcopy;
                    cnt       <= len_q;
                    rpt_pulse <= 1'b1;
                end else begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt - LW'(1);
                end
            end
        end
    end

    // Outputs decode flops only, so they never see input-to-output paths.
    always_comb begin
        dout_vld = (state == ST_SEND);
        busy     = (state == ST_SEND);
        dout     = (state == ST_SEND) ? shreg[0] : 1'b0;
        done     = (state == ST_DONE) || rpt_pulse;
    end

endmodule

// File: tb/tb_seq_gen.sv
// Randomized and directed bench for seq_gen against a bit-queue level model.
module tb_seq_gen;

    localparam int W  = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  pat;
    logic [LW-1:0] len;
    logic          rpt;
    logic          abort;
    logic          dout_rdy;
    logic          dout;
    logic          dout_vld;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Model: an active transmission is a pattern, a bit count and a position.
    bit        m_act;
    bit        m_rpt;
    bit        m_done;
    bit        m_in_done;
    bit [15:0] m_pat;
    int        m_n;
    int        m_pos;

    bit        collect;
    bit        got_bits[$];

    seq_gen #(.W(W), .LW(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pat      (pat),
        .len      (len),
        .rpt      (rpt),
        .abort    (abort),
        .dout_rdy (dout_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_act     = 1'b0;
        m_rpt     = 1'b0;
        m_done    = 1'b0;
        m_in_done = 1'b0;
        m_pat     = '0;
        m_n       = 0;
        m_pos     = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".dout_vld"}, 32'(dout_vld), 32'(m_act));
        check({where, ".busy"},     32'(busy),     32'(m_act));
        check({where, ".dout"},     32'(dout),     m_act ? 32'(m_pat[m_pos]) : 32'd0);
        check({where, ".done"},     32'(done),     32'(m_done));
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_clear();
        end else if (abort) begin
            m_act     = 1'b0;
            m_done    = 1'b0;
            m_in_done = 1'b0;
        end else if (m_act) begin
            m_done = 1'b0;
            if (dout_rdy) begin
                m_pos++;
                if (m_pos == m_n) begin
                    m_done = 1'b1;
                    if (m_rpt) begin
                        m_pos = 0;
                    end else begin
                        m_act     = 1'b0;
                        m_in_done = 1'b1;
                    end
                end
            end
        end else begin
            m_done = 1'b0;
            if (m_in_done) begin
                m_in_done = 1'b0;
            end else if (start && len != 0) begin
                m_act = 1'b1;
                m_pat = pat;
                m_n   = (int'(len) > W) ? W : int'(len);
                m_pos = 0;
                m_rpt = rpt;
            end
        end
    endtask

    // One clock: entered and left at posedge+1.
    task automatic cyc();
        @(negedge clk);
        check_outputs("cyc");
        if (collect && dout_vld && dout_rdy) got_bits.push_back(dout);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        abort = 1'b0;
        rpt   = 1'b0;
        len   = '0;
        pat   = '0;
        dout_rdy = 1'b1;
    endtask

    task automatic send(input logic [15:0] p, input logic [LW-1:0] l, input logic r);
        pat   = p;
        len   = l;
        rpt   = r;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pat   = $urandom;
        len   = LW'($urandom);
        rpt   = $urandom_range(0, 1);
    endtask

    initial begin
        logic [17:0] stream_exp;
        logic [17:0] stream_got;

        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        #1;
        check_outputs("reset");
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Plain 16-bit send, full throughput.
        send(16'hC5A3, 5'd16, 1'b0);
        repeat (19) cyc();

        // Same send with a three-cycle stall early on.
        send(16'hC5A3, 5'd16, 1'b0);
        cyc();
        cyc();
        dout_rdy = 1'b0;
        repeat (3) cyc();
        dout_rdy = 1'b1;
        repeat (18) cyc();

        // Repeat mode, then abort mid-pass.
        send(16'h000D, 5'd4, 1'b1);
        repeat (13) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (3) cyc();

        // len=0 ignored, len=20 clamps to 16.
        send(16'hFFFF, 5'd0, 1'b0);
        repeat (3) cyc();
        send(16'hA5F0, 5'd20, 1'b0);
        repeat (20) cyc();

        // Asynchronous reset in the middle of a send, then restart.
        send(16'h3C96, 5'd12, 1'b0);
        repeat (5) cyc();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.dout_vld", 32'(dout_vld), 32'd0);
        check("arst.dout",     32'(dout),     32'd0);
        check("arst.busy",     32'(busy),     32'd0);
        check("arst.done",     32'(done),     32'd0);
        model_clear();
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        send(16'h3C96, 5'd12, 1'b0);
        repeat (15) cyc();

        // 18-bit stream as a 16-bit then a 2-bit send.
        stream_exp = 18'b000011101100011100;
        got_bits.delete();
        collect = 1'b1;
        send(stream_exp[15:0], 5'd16, 1'b0);
        repeat (17) cyc();
        send({14'd0, stream_exp[17:16]}, 5'd2, 1'b0);
        repeat (4) cyc();
        collect = 1'b0;
        check("stream.count", 32'(got_bits.size()), 32'd18);
        stream_got = '0;
        for (int i = 0; i < 18 && i < got_bits.size(); i++) stream_got[i] = got_bits[i];
        check("stream.bits", 32'(stream_got), 32'(stream_exp));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            pat      = $urandom;
            len      = LW'($urandom);
            rpt      = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 60) == 0);
            dout_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle_inputs();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        collect = 1'b0;
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
